// File: rtl/gf2n_mult_pipe.sv
// Pipelined GF(2^N) multiplier/squarer: CH channels share one operand x.
// Elastic valid/ready pipeline with bubble collapse and a synchronous flush.
module gf2n_mult_pipe #(
   parameter int             N      = 4,
   parameter logic [N-1:0]   POLY   = 4'b0011,
   parameter int             CH     = 2,
   parameter int             STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_mode,
   input  logic [N-1:0]      in_x,
   input  logic [CH*N-1:0]   in_y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CH*N-1:0]   out_p,
   output logic [2:0]        occupancy
);

   localparam int PW = 2*N-1;

   function automatic logic [PW-1:0] clmul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [PW-1:0] acc;
      logic [PW-1:0] ax;
      acc = '0;
      ax  = {{(N-1){1'b0}}, a};
      for (int i = 0; i < N; i++) begin
         if (b[i]) acc = acc ^ (ax << i);
      end
      return acc;
   endfunction

   // Fold each bit above x^(N-1) back down using x^N = POLY, highest bit first.
   function automatic logic [N-1:0] reduce(input logic [PW-1:0] p);
      logic [PW-1:0] r;
      logic [PW-1:0] pw;
      r  = p;
      pw = {{(N-1){1'b0}}, POLY};
      for (int i = PW-1; i >= N; i--) begin
         if (r[i]) begin
            r    = r ^ (pw << (i-N));
            r[i] = 1'b0;
         end
      end
      return r[N-1:0];
   endfunction

   function automatic logic [CH*PW-1:0] prod_all(input logic [N-1:0] x,
                                                 input logic [CH*N-1:0] y,
                                                 input logic sq);
      logic [CH*PW-1:0] r;
      logic [N-1:0]     yc;
      r = '0;
      for (int c = 0; c < CH; c++) begin
         yc = y[c*N +: N];
         r[c*PW +: PW] = clmul(yc, sq ? yc : x);
      end
      return r;
   endfunction

   function automatic logic [CH*N-1:0] reduce_all(input logic [CH*PW-1:0] p);
      logic [CH*N-1:0] r;
      r = '0;
      for (int c = 0; c < CH; c++) begin
         r[c*N +: N] = reduce(p[c*PW +: PW]);
      end
      return r;
   endfunction

   logic [STAGES-1:0] vld_p;
   logic [STAGES-1:0] take;
   logic [CH*N-1:0]   out_data;

   // take[k]: stage k loads this cycle, i.e. it is empty or its beat moves on.
   always_comb begin
      take = '0;
      take[STAGES-1] = !vld_p[STAGES-1] || out_ready;
      for (int k = STAGES-2; k >= 0; k--) begin
         take[k] = !vld_p[k] || take[k+1];
      end
   end

   assign in_ready  = take[0] && !clear;
   assign out_valid = vld_p[STAGES-1];
   assign out_p     = vld_p[STAGES-1] ? out_data : '0;

   always_comb begin
      occupancy = '0;
      for (int k = 0; k < STAGES; k++) begin
         occupancy = occupancy + {2'b00, vld_p[k]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p <= '0;
      end else if (clear) begin
         vld_p <= '0;
      end else begin
         if (take[0]) vld_p[0] <= in_valid && in_ready;
         for (int k = 1; k < STAGES; k++) begin
            if (take[k]) vld_p[k] <= vld_p[k-1];
         end
      end
   end

   generate
      if (STAGES == 1) begin : g_one
         logic [CH*N-1:0] res_p0;

         // Stage 0 boundary: full multiply and reduction in one cycle.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               res_p0 <= '0;
            end else if (take[0]) begin
               res_p0 <= reduce_all(prod_all(in_x, in_y, in_mode));
            end
         end

         assign out_data = res_p0;
      end else begin : g_multi
         logic [CH*PW-1:0] prod_p0;
         logic [CH*N-1:0]  res_p [1:STAGES-1];

         // Stage 0 boundary: unreduced carry-less product.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               prod_p0 <= '0;
            end else if (take[0]) begin
               prod_p0 <= prod_all(in_x, in_y, in_mode);
            end
         end

         // Stage 1 boundary: reduced result; later stages are pure delay.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 1; k < STAGES; k++) res_p[k] <= '0;
            end else begin
               if (take[1]) res_p[1] <= reduce_all(prod_p0);
               for (int k = 2; k < STAGES; k++) begin
                  if (take[k]) res_p[k] <= res_p[k-1];
               end
            end
         end

         assign out_data = res_p[STAGES-1];
      end
   endgenerate

endmodule

// File: tb/tb_gf2n_mult_pipe.sv
// Directed bench for gf2n_mult_pipe (N=4, x^4+x+1, CH=2, STAGES=2).
// Expected results come from a shift-and-reduce GF model via a scoreboard queue.
module tb_gf2n_mult_pipe;
   localparam int           N      = 4;
   localparam logic [N-1:0] POLY   = 4'b0011;
   localparam int           CH     = 2;
   localparam int           STAGES = 2;

   logic            clk = 1'b0;
   logic            rst_n, clear, in_valid, in_ready, in_mode;
   logic            out_valid, out_ready;
   logic [N-1:0]    in_x;
   logic [CH*N-1:0] in_y, out_p, held;
   logic [2:0]      occupancy;

   logic [CH*N-1:0] exp_q [$];
   int checks = 0;
   int errors = 0;

   gf2n_mult_pipe #(.N(N), .POLY(POLY), .CH(CH), .STAGES(STAGES)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_x(in_x), .in_y(in_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] r, t;
      r = '0;
      t = a;
      for (int i = 0; i < N; i++) begin
         if (b[i]) r = r ^ t;
         t = t[N-1] ? ((t << 1) ^ POLY) : (t << 1);
      end
      return r;
   endfunction

   function automatic logic [CH*N-1:0] model(input logic [N-1:0] x, input logic [CH*N-1:0] y,
                                             input logic sq);
      logic [CH*N-1:0] r;
      logic [N-1:0]    yc;
      r = '0;
      for (int c = 0; c < CH; c++) begin
         yc = y[c*N +: N];
         r[c*N +: N] = gf_mul(yc, sq ? yc : x);
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clock: score handshakes mid-cycle, then return just after the edge.
   task automatic cyc();
      @(negedge clk);
      if (clear) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out", {24'd0, out_p}, 32'hFFFF_FFFF);
            else                   chk("scoreboard", {24'd0, out_p}, {24'd0, exp_q.pop_front()});
         end
         if (in_valid && in_ready) exp_q.push_back(model(in_x, in_y, in_mode));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [N-1:0] x, input logic [CH*N-1:0] y, input logic m);
      in_x = x; in_y = y; in_mode = m; in_valid = 1'b1;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() > 0; i++) cyc();
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
      in_x = '0; in_y = '0; out_ready = 1'b1;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_p", out_p, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // multiply, latency
      beat(4'h2, 8'h83, 1'b0);
      cyc();
      in_valid = 1'b0;
      chk("lat1_valid", out_valid, 0);
      chk("idle_out_p_zero", out_p, 0);
      cyc();
      chk("lat2_valid", out_valid, 1);
      chk("mul_p", out_p, 8'h36);
      drain(10);

      // streaming
      beat(4'h7, 8'h31, 1'b0); cyc();
      beat(4'h3, 8'h5A, 1'b0); cyc();
      chk("stream_v1", out_valid, 1);
      chk("stream_p1", out_p, 8'h97);
      beat(4'hE, 8'hC7, 1'b0); cyc();
      in_valid = 1'b0;
      chk("stream_v2", out_valid, 1);
      cyc();
      chk("stream_v3", out_valid, 1);
      cyc();
      chk("stream_end", out_valid, 0);
      drain(5);

      // squaring
      beat(4'h5, 8'hF2, 1'b1); cyc();
      in_valid = 1'b0;
      cyc();
      chk("sq_p", out_p, 8'hA4);
      drain(5);

      // backpressure
      out_ready = 1'b0;
      beat(4'h9, 8'h12, 1'b0); cyc();
      beat(4'hB, 8'h6D, 1'b0); cyc();
      beat(4'h4, 8'hFE, 1'b1);
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_occ", occupancy, 2);
      chk("bp_valid", out_valid, 1);
      held = out_p;
      cyc();
      chk("bp_stable", out_p, held);
      chk("bp_in_ready2", in_ready, 0);
      out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk("full_thru_occ", occupancy, 2);
      cyc(); cyc();
      chk("bp_drained", out_valid, 0);
      drain(5);

      // clear
      out_ready = 1'b0;
      beat(4'h1, 8'h23, 1'b0); cyc();
      beat(4'h2, 8'h45, 1'b0); cyc();
      clear = 1'b1;
      beat(4'h3, 8'h67, 1'b0);
      #1;
      chk("clr_in_ready", in_ready, 0);
      chk("clr_pre_occ", occupancy, 2);
      cyc();
      clear = 1'b0; in_valid = 1'b0;
      chk("clr_occ", occupancy, 0);
      chk("clr_valid", out_valid, 0);
      chk("clr_out_p", out_p, 0);
      out_ready = 1'b1;
      beat(4'h3, 8'h44, 1'b0); cyc();
      in_valid = 1'b0;
      drain(5);

      // reset mid-stream
      out_ready = 1'b0;
      beat(4'hA, 8'h3C, 1'b0); cyc();
      beat(4'hD, 8'h81, 1'b1); cyc();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_out_p", out_p, 0);
      chk("mid_rst_occ", occupancy, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      beat(4'h6, 8'h9B, 1'b0);
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      cyc();
      in_valid = 1'b0;
      chk("post_rst_occ", occupancy, 1);
      drain(5);
      cyc(); cyc(); cyc();
      chk("post_rst_quiet", out_valid, 0);

      chk("q_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/gf2n_mult_pipe.md
GF2N_MULT_PIPE -- requirements
Module: gf2n_mult_pipe

Interface
REQ-001 SHALL have parameter N, default 4: GF(2^N) element width, legal range 2..8.
REQ-002 SHALL have parameter POLY, default 4'b0011: low N coefficients of the monic reduction polynomial; default is x^4+x+1.
REQ-003 SHALL have parameter CH, default 2: number of channels sharing one common operand, legal range 1..8.
REQ-004 SHALL have parameter STAGES, default 2: pipeline register depth, legal range 1..4.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; these are fixed.
REQ-006 SHALL have the following ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of all in-flight entries
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts a beat this cycle
- in_mode  in  1  0 = multiply, 1 = square
- in_x  in  N  common operand
- in_y  in  CH*N  channel operands; channel i is bits [i*N +: N]
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts the result
- out_p  out  CH*N  channel results; channel i is bits [i*N +: N]
- occupancy  out  3  number of valid pipeline stages, 0..STAGES

Function
REQ-007 SHALL compute each channel in polynomial basis, modulo x^N + POLY:
- mode 0: p_i = y_i * x
- mode 1: p_i = y_i * y_i, with in_x ignored.
REQ-008 SHALL transfer an input beat only when in_valid && in_ready at a rising clk edge.
REQ-009 SHALL transfer an output beat only when out_valid && out_ready at a rising clk edge.
REQ-010 SHALL implement STAGES stage registers, each holding one valid bit and a data field.
REQ-011 SHALL let stage k advance when stage k+1 is empty or advancing; the last stage advances when out_ready = 1.
REQ-012 SHALL drive in_ready = !v[0] || adv[0], as a combinational function of the stage valids and out_ready only.
REQ-013 SHALL collapse bubbles: a beat moves forward whenever the stage ahead is free.
REQ-014 SHALL give a latency of exactly STAGES cycles from acceptance to out_valid when there is no backpressure.
REQ-015 SHALL sustain a throughput of 1 beat per cycle.
REQ-016 SHALL, when STAGES >= 2, register the unreduced (2N-1)-bit carry-less product in stage 1 and perform the reduction before stage 2; further stages are delay only.
REQ-017 SHALL, when STAGES = 1, fully reduce the product before stage 1.
REQ-018 SHALL hold out_p and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL deliver results in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-020 SHALL drive out_p = 0 whenever out_valid = 0.
REQ-021 SHALL, on clear = 1 at a clock edge:
- clear every valid bit to 0; data contents are don't-care
- accept no input beat in that cycle; in_ready is forced to 0 while clear = 1
- return the block to empty, so occupancy = 0 on the next cycle.
REQ-022 SHALL, on simultaneous input and output transfers with the pipeline full, accept the input; occupancy stays at STAGES.
REQ-023 SHALL update occupancy every cycle as the count of set valid bits.
REQ-024 SHALL drive out_valid = 1 and in_ready = 0 when the pipeline is full and out_ready = 0.

Reset
REQ-025 SHALL, while rst_n = 0, asynchronously clear all valid bits and data registers, independent of clk.
REQ-026 SHALL drive the following during reset:
- out_valid = 0
- out_p = 0
- occupancy = 0
- in_ready = 1 (empty pipeline).
REQ-027 SHALL discard in-flight beats if reset asserts mid-operation; nothing is emitted after release.
REQ-028 SHALL accept input on the first rising clk edge after rst_n deasserts.

Verification (N=4, POLY=0011, CH=2, STAGES=2)
REQ-029 Reset: rst_n=0 mid-stream with 2 beats in flight -> immediately out_valid=0, out_p=0, occupancy=0, in_ready=1; no output after release.
REQ-030 Multiply: x=0x2, y={0x8,0x3}, mode 0, out_ready=1 -> out_valid exactly 2 cycles later with out_p={0x3,0x6}.
REQ-031 Streaming: three back-to-back beats with out_ready=1 -> three consecutive output cycles in order; for example, x=0x7, y={0x3,0x1} -> {0x9,0x7}.
REQ-032 Squaring: mode 1, y={0xF,0x2}, x=0x5 -> out_p={0xA,0x4}.
REQ-033 Backpressure:
- out_ready=0 and in_valid held -> 2 beats accepted, then in_ready=0, occupancy=2, out_p stable
- out_ready=1 for 3 cycles -> beats drained in order with a simultaneous accept on the release cycle.
REQ-034 Clear: clear=1 with occupancy=2 -> next cycle occupancy=0, out_valid=0, with no beat accepted in the clear cycle.
